gb_frame_sequencer: RTL

- Generates the 512 Hz APU frame-sequencer events (length, sweep, envelope) that drive the channel units. This block is the source of the sweep pulse the channel-1 sweep unit consumes.
- Free-running 8-step sequencer clocked by the 2^22 Hz system clock.
- Emits single-cycle strobes: length on even steps, sweep on steps 2 and 6, envelope on step 7.
- Held idle while the APU is powered off.

---
 rtl/gb_frame_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/gb_frame_sequencer.sv
// rtl/gb_frame_sequencer.sv - 512 Hz APU frame sequencer (length/sweep/envelope strobes)
//
// Ports:
//   clk              system clock, 2^22 Hz
//   reset            synchronous, active-high reset
//   apu_enable       NR52 bit 7; 0 holds the sequencer idle at step 0
//   div_bit          timer DIV bit (bit 4, bit 5 in double speed); used only
//                    when FS_EXT_DIV_EN is defined
//   clk_length       one-cycle strobe to the length counters
//   clk_sweep        one-cycle strobe to the channel-1 sweep unit
//   clk_envelope     one-cycle strobe to the volume envelopes
//   step             step index that the next tick will execute
//   length_skip_next 1 when the next tick will not clock length
//
// Build option: define FS_EXT_DIV_EN to take ticks from falling edges of
// div_bit instead of the internal DIV_COUNT divider.
module gb_frame_sequencer #(
  parameter int DIV_COUNT = 8192,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_bit,
  output logic       clk_length,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] step,
  output logic       length_skip_next
);

  logic tick;

`ifdef FS_EXT_DIV_EN
  // div_prev keeps tracking the DIV bit while the APU is off, so a bit that
  // was already high when the APU powers up still yields a tick on its fall.
  logic div_prev;

  localparam int unused_div_params = DIV_COUNT + CNT_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_bit;
    end
  end

  assign tick = apu_enable && div_prev && !div_bit;
`else
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] divider;
  logic             unused_div_bit;

  assign unused_div_bit = div_bit;

  always_ff @(posedge clk) begin
    if (reset || !apu_enable) begin
      divider <= '0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
    end else begin
      divider <= divider + CNT_W'(1);
    end
  end

  assign tick = apu_enable && (divider == DIV_LAST);
`endif

  // Strobes are decoded from the step being executed and registered, so the
  // strobe cycle already shows the incremented step.
  always_ff @(posedge clk) begin
    if (reset || !apu_enable) begin
      step         <= 3'd0;
      clk_length   <= 1'b0;
      clk_sweep    <= 1'b0;
      clk_envelope <= 1'b0;
    end else begin
      clk_length   <= tick && !step[0];
      clk_sweep    <= tick && ((step == 3'd2) || (step == 3'd6));
      clk_envelope <= tick && (step == 3'd7);
      if (tick) begin
        step <= step + 3'd1;
      end
    end
  end

  assign length_skip_next = step[0];

endmodule
